// File: rtl/coerencia_pkg.sv
// Shared definitions for the MSI snooping-bus coherence system.
// Contents: bus message codes, MSI line states, processor op codes and the
// state encoding of the bus arbiter FSM.
package coerencia_pkg;

    // Bus message codes carried on bus_msg / req_msg
    typedef enum logic [1:0] {
        invalidar    = 2'b00,
        msgReadMiss  = 2'b01,
        msgWriteMiss = 2'b10,
        semMensagem  = 2'b11
    } msg_t;

    // MSI cache line states
    typedef enum logic [1:0] {
        MsiInvalido      = 2'b00,
        MsiCompartilhado = 2'b01,
        MsiModificado    = 2'b10
    } msi_t;

    // Processor-side operations
    typedef enum logic [1:0] {
        OpNenhuma = 2'b00,
        OpLeitura = 2'b01,
        OpEscrita = 2'b10
    } op_t;

    // Bus arbiter FSM states
    typedef enum logic [1:0] {
        StOcioso    = 2'b00,
        StDifusao   = 2'b01,
        StWriteback = 2'b10,
        StFim       = 2'b11
    } arb_state_t;

    localparam int unsigned STATS_W = 16;

endpackage

// File: rtl/arbitro_rr_sel.sv
// Combinational round-robin picker.
// Ports:
//   eligible  in   NUM_PROC  candidate vector
//   ptr       in   IDX_W     last winner; search starts at ptr+1
//   winner    out  IDX_W     first eligible index after ptr (mod NUM_PROC)
//   any_valid out  1         at least one candidate is eligible
module arbitro_rr_sel #(
    parameter int unsigned NUM_PROC = 3,
    localparam int unsigned IDX_W = $clog2(NUM_PROC)
) (
    input  logic [NUM_PROC-1:0] eligible,
    input  logic [IDX_W-1:0]    ptr,
    output logic [IDX_W-1:0]    winner,
    output logic                any_valid
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = '0;
        // Scan from the farthest offset down so the closest candidate after ptr is written last.
        for (int unsigned off = NUM_PROC; off >= 1; off--) begin
            idx = IDX_W'((32'(ptr) + off) % NUM_PROC);
            if (eligible[idx]) begin
                winner    = idx;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbitro_barramento.sv
// Round-robin arbiter and sequencer for the shared MSI snooping bus.
// Grants one requester at a time, broadcasts its message for one cycle, optionally holds the bus
// for a write-back window, then pulses done for the winner. All outputs are registered.
// Ports:
//   clock, reset_n          clock (rising edge) and asynchronous active-low reset
//   req/req_msg/req_tag/req_wb  per-processor request, message, tag, write-back flag
//   gnt, done               one-hot grant (whole transaction) and 1-cycle completion pulse
//   bus_valid/msg/tag/src   broadcast message, valid for one cycle per transaction
//   wb_busy                 write-back window active
//   grant_cnt               per-processor 16-bit grant counters (only with ARB_STATS_EN)
// Configuration: define ARB_STATS_EN to add grant_cnt and its counters.
module arbitro_barramento
    import coerencia_pkg::*;
#(
    parameter int unsigned NUM_PROC  = 3,
    parameter int unsigned TAG_W     = 8,
    parameter int unsigned WB_CYCLES = 4
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [NUM_PROC-1:0]         req,
    input  logic [2*NUM_PROC-1:0]       req_msg,
    input  logic [TAG_W*NUM_PROC-1:0]   req_tag,
    input  logic [NUM_PROC-1:0]         req_wb,
    output logic [NUM_PROC-1:0]         gnt,
    output logic [NUM_PROC-1:0]         done,
    output logic                        bus_valid,
    output logic [1:0]                  bus_msg,
    output logic [TAG_W-1:0]            bus_tag,
    output logic [$clog2(NUM_PROC)-1:0] bus_src,
`ifdef ARB_STATS_EN
    output logic [16*NUM_PROC-1:0]      grant_cnt,
`endif
    output logic                        wb_busy
);

    localparam int unsigned IDX_W = $clog2(NUM_PROC);
    localparam int unsigned CNT_W = (WB_CYCLES > 1) ? $clog2(WB_CYCLES) : 1;

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] ptr_q, win_q, winner;
    logic [1:0]       msg_q, sel_msg;
    logic [TAG_W-1:0] tag_q, sel_tag;
    logic             wb_q, sel_wb, any_valid;
    logic [NUM_PROC-1:0] eligible;

    // The done mask keeps the just-finished winner from being regranted in its done cycle.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_PROC; i++) begin
            eligible[i] = req[i] && (req_msg[2*i +: 2] != semMensagem) && !done[i];
        end
    end

    arbitro_rr_sel #(
        .NUM_PROC(NUM_PROC)
    ) u_sel (
        .eligible (eligible),
        .ptr      (ptr_q),
        .winner   (winner),
        .any_valid(any_valid)
    );

    always_comb begin
        sel_msg = semMensagem;
        sel_tag = '0;
        sel_wb  = 1'b0;
        for (int i = 0; i < NUM_PROC; i++) begin
            if (winner == IDX_W'(i)) begin
                sel_msg = req_msg[2*i +: 2];
                sel_tag = req_tag[TAG_W*i +: TAG_W];
                sel_wb  = req_wb[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StOcioso: begin
                if (any_valid) state_d = StDifusao;
            end
            StDifusao: begin
                if (wb_q) begin
                    state_d = StWriteback;
                    cnt_d   = CNT_W'(WB_CYCLES - 1);
                end else begin
                    state_d = StFim;
                end
            end
            StWriteback: begin
                if (cnt_q == '0) state_d = StFim;
                else             cnt_d   = cnt_q - 1'b1;
            end
            StFim:   state_d = StOcioso;
            default: state_d = StOcioso;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StOcioso;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are registered images of the state: each appears one cycle after its state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gnt       <= '0;
            done      <= '0;
            bus_valid <= 1'b0;
            bus_msg   <= semMensagem;
            bus_tag   <= '0;
            bus_src   <= '0;
            wb_busy   <= 1'b0;
            ptr_q     <= IDX_W'(NUM_PROC - 1);
            win_q     <= '0;
            msg_q     <= semMensagem;
            tag_q     <= '0;
            wb_q      <= 1'b0;
        end else begin
            bus_valid <= (state_q == StDifusao);
            bus_msg   <= (state_q == StDifusao) ? msg_q : semMensagem;
            bus_tag   <= (state_q == StDifusao) ? tag_q : '0;
            bus_src   <= (state_q == StDifusao) ? win_q : '0;
            wb_busy   <= (state_q == StWriteback);
            done      <= (state_q == StFim) ? gnt : '0;
            if (state_q == StFim) ptr_q <= win_q;
            if (state_q == StOcioso && any_valid) begin
                gnt   <= NUM_PROC'(1) << winner;
                win_q <= winner;
                msg_q <= sel_msg;
                tag_q <= sel_tag;
                wb_q  <= sel_wb;
            end else if (done != '0) begin
                gnt <= '0;
            end
        end
    end

`ifdef ARB_STATS_EN
    logic [STATS_W-1:0] stats_q [NUM_PROC];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PROC; i++) stats_q[i] <= '0;
        end else if (state_q == StFim) begin
            stats_q[win_q] <= stats_q[win_q] + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_PROC; g++) begin : g_cnt
        assign grant_cnt[16*g +: 16] = stats_q[g];
    end
`endif

endmodule

// File: tb/tb_arbitro_barramento.sv
// Randomized self-checking bench for arbitro_barramento against a transaction-timeline model.
module tb_arbitro_barramento;

    localparam int unsigned NP = 3;
    localparam int unsigned TW = 8;
    localparam int unsigned WB = 4;
    localparam int unsigned SW = $clog2(NP);

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [NP-1:0]     req = '0, req_wb = '0, gnt, done;
    logic [2*NP-1:0]   req_msg = '0;
    logic [TW*NP-1:0]  req_tag = '0;
    logic              bus_valid, wb_busy;
    logic [1:0]        bus_msg;
    logic [TW-1:0]     bus_tag;
    logic [SW-1:0]     bus_src;
`ifdef ARB_STATS_EN
    logic [16*NP-1:0]  grant_cnt;
`endif

    arbitro_barramento #(.NUM_PROC(NP), .TAG_W(TW), .WB_CYCLES(WB)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .req      (req),
        .req_msg  (req_msg),
        .req_tag  (req_tag),
        .req_wb   (req_wb),
        .gnt      (gnt),
        .done     (done),
        .bus_valid(bus_valid),
        .bus_msg  (bus_msg),
        .bus_tag  (bus_tag),
        .bus_src  (bus_src),
`ifdef ARB_STATS_EN
        .grant_cnt(grant_cnt),
`endif
        .wb_busy  (wb_busy)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: each transaction is a timeline anchored at its arbitration edge t_e.
    int e;          // edges since reset release
    int free_e;     // earliest edge for the next arbitration
    bit txn;        // a transaction exists since reset
    int t_e, t_w, t_len;
    logic [1:0]    t_msg;
    logic [TW-1:0] t_tag;
    int ptr;
    int cnt_model [NP];

    task automatic model_edge();
        int i;
        bit masked;
        if (e >= free_e) begin
            for (int off = 1; off <= NP; off++) begin
                i = (ptr + off) % NP;
                masked = txn && (e == free_e) && (i == t_w);
                if (req[i] && req_msg[2*i +: 2] != 2'b11 && !masked) begin
                    t_w   = i;
                    t_e   = e;
                    t_msg = req_msg[2*i +: 2];
                    t_tag = req_tag[TW*i +: TW];
                    t_len = req_wb[i] ? WB : 0;
                    txn   = 1'b1;
                    ptr   = i;
                    free_e = e + 3 + t_len;
                    cnt_model[i]++;
                    break;
                end
            end
        end
    endtask

    task automatic check_cycle(input int c);
        logic [NP-1:0] eg, ed;
        logic ev, ewb;
        eg = '0; ed = '0; ev = 1'b0; ewb = 1'b0;
        if (txn) begin
            if (c >= t_e + 1 && c <= t_e + 3 + t_len) eg = NP'(1) << t_w;
            if (c == t_e + 3 + t_len) ed = NP'(1) << t_w;
            ev  = (c == t_e + 2);
            ewb = (c >= t_e + 3 && c <= t_e + 2 + t_len);
        end
        check_eq("gnt", gnt, eg);
        check_eq("done", done, ed);
        check_eq("bus_valid", bus_valid, ev);
        check_eq("wb_busy", wb_busy, ewb);
        if (ev) begin
            check_eq("bus_msg", bus_msg, t_msg);
            check_eq("bus_tag", bus_tag, t_tag);
            check_eq("bus_src", bus_src, t_w);
        end
    endtask

    task automatic new_req(input int i);
        req[i] = ($urandom_range(0, 3) != 0);
        req_msg[2*i +: 2] = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        req_tag[TW*i +: TW] = TW'($urandom);
        req_wb[i] = ($urandom_range(0, 2) == 0);
    endtask

    // mode 0: hold inputs, 1: winner drops req at done, 2: random requesters
    task automatic drive(input int mode, input int c);
        bit fin;
        fin = txn && (c == t_e + 3 + t_len);
        if (mode == 1 && fin) req[t_w] = 1'b0;
        if (mode == 2) begin
            for (int i = 0; i < NP; i++) begin
                if (fin && i == t_w) begin
                    req[i] = 1'b0;
                    if ($urandom_range(0, 1) == 1) new_req(i);
                end else if (txn && i == t_w && c < t_e + 3 + t_len) begin
                    // churn on the granted requester must be ignored
                    if ($urandom_range(0, 3) == 0) new_req(i);
                end else if (req[i] && req_msg[2*i +: 2] != 2'b11) begin
                    req[i] = 1'b1;
                end else if ($urandom_range(0, 2) == 0) begin
                    new_req(i);
                end
            end
        end
    endtask

    task automatic run(input int mode, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            model_edge();
            #1;
            check_cycle(e + 1);
            drive(mode, e + 1);
            e++;
        end
    endtask

    task automatic check_reset_vals(input string w);
        check_eq({w, "_gnt"}, gnt, 0);
        check_eq({w, "_done"}, done, 0);
        check_eq({w, "_bus_valid"}, bus_valid, 0);
        check_eq({w, "_bus_msg"}, bus_msg, 2'b11);
        check_eq({w, "_bus_tag"}, bus_tag, 0);
        check_eq({w, "_bus_src"}, bus_src, 0);
        check_eq({w, "_wb_busy"}, wb_busy, 0);
`ifdef ARB_STATS_EN
        for (int i = 0; i < NP; i++) check_eq({w, "_grant_cnt"}, grant_cnt[16*i +: 16], 0);
`endif
    endtask

    // Returns at a falling edge with reset released; the next rising edge is model edge 0.
    task automatic apply_reset();
        reset_n = 1'b0;
        req = '0; req_msg = '0; req_tag = '0; req_wb = '0;
        repeat (2) @(negedge clock);
        check_reset_vals("reset");
        reset_n = 1'b1;
        e = 0; free_e = 0; txn = 1'b0; ptr = NP - 1;
        t_e = 0; t_w = 0; t_len = 0;
        for (int i = 0; i < NP; i++) cnt_model[i] = 0;
    endtask

    initial begin
        // Single request, proc 0 readMiss
        apply_reset();
        req = 3'b001; req_msg = 6'b00_00_01; req_tag = 24'h0000A5;
        run(1, 8);

        // All three requesting continuously: strict 0,1,2,0 rotation
        apply_reset();
        req = 3'b111; req_msg = 6'b01_01_01; req_tag = 24'h332211;
        run(0, 20);

        // Write-back transaction on proc 1
        apply_reset();
        req = 3'b010; req_msg = 6'b00_10_00; req_wb = 3'b010; req_tag = 24'h00C300;
        run(1, 12);

        // msg 11 is never granted; a later invalidar on proc 0 is
        apply_reset();
        req = 3'b100; req_msg = 6'b11_00_00;
        run(0, 6);
        req = 3'b101; req_tag = 24'h00005A;
        run(1, 8);

        // Randomized traffic
        apply_reset();
        run(2, 3000);
        req = '0;
        run(0, 15);
`ifdef ARB_STATS_EN
        for (int i = 0; i < NP; i++) check_eq("grant_cnt", grant_cnt[16*i +: 16], 16'(cnt_model[i]));
`endif

        // Asynchronous reset in the middle of a write-back
        apply_reset();
        req = 3'b010; req_msg = 6'b00_01_00; req_wb = 3'b010;
        run(0, 4);
        check_eq("pre_reset_wb_busy", wb_busy, 1);
        #2 reset_n = 1'b0;
        #1 check_reset_vals("async");
        apply_reset();
        req = 3'b110; req_msg = 6'b01_01_00; req_tag = 24'h778800;
        run(1, 12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
